clk_controller: RTL and testbench

Parametrised CPU clock generator for the SAP-2 core, clocked from the board oscillator.
- Free-run mode: four selectable speeds, latched at period boundaries.
- Single-step mode: one fixed-width high pulse per step-button rising edge.
- Halt stop: the current high phase always completes, so no runt pulse is produced.
- Outputs: clk_out, plus one-cycle rise/fall strobes for logic that uses clk_in enables instead of clk_out as a clock.

---
 rtl/clk_controller.sv | 180 ++++++++++++++++++
 tb/tb_clk_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_controller.sv
// clk_controller: CPU clock generator for the SAP-2 core.
// Produces a divided free-running clock (four speeds), single-step pulses
// from a debounced button, and one-cycle rise/fall strobes aligned with clk_out.
// A halt never truncates a high phase; only enable low or reset cut it short.
module clk_controller #(
  parameter int DIV_WIDTH        = 25,
  parameter int DIV_0            = 25_000_000,
  parameter int DIV_1            = 2_500_000,
  parameter int DIV_2            = 250_000,
  parameter int DIV_3            = 2_500,
  parameter int STEP_HIGH_CYCLES = 1_000
) (
  input  logic       i_clk_in,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_hlt,
  input  logic       i_mode,
  input  logic [1:0] i_speed_sel,
  input  logic       i_step,
  output logic       o_clk_out,
  output logic       o_clk_rise,
  output logic       o_clk_fall,
  output logic       o_running
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN_LOW   = 2'd1,
    ST_RUN_HIGH  = 2'd2,
    ST_STEP_HIGH = 2'd3
  } state_t;

  // A zero step width would never terminate the pulse, so it is clamped to one.
  localparam int STEP_LEN = (STEP_HIGH_CYCLES < 1) ? 1 : STEP_HIGH_CYCLES;
  localparam logic [DIV_WIDTH-1:0] CNT_ZERO  = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] STEP_LAST = DIV_WIDTH'(STEP_LEN - 1);
  localparam logic [DIV_WIDTH-1:0] RST_DIV   =
    (DIV_WIDTH'(DIV_0) == CNT_ZERO) ? CNT_ONE : DIV_WIDTH'(DIV_0);

  // Map a speed selection to its half-period; a zero divisor becomes one so
  // the terminal-count compare never wraps.
  function automatic logic [DIV_WIDTH-1:0] sel_div(input logic [1:0] sel);
    logic [DIV_WIDTH-1:0] v;
    case (sel)
      2'd0:    v = DIV_WIDTH'(DIV_0);
      2'd1:    v = DIV_WIDTH'(DIV_1);
      2'd2:    v = DIV_WIDTH'(DIV_2);
      2'd3:    v = DIV_WIDTH'(DIV_3);
      default: v = DIV_WIDTH'(DIV_0);
    endcase
    if (v == CNT_ZERO) begin
      sel_div = CNT_ONE;
    end else begin
      sel_div = v;
    end
  endfunction

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic                 r_step_d;
  logic                 r_clk_out;
  logic                 r_clk_rise;
  logic                 r_clk_fall;
  logic                 r_running;

  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [DIV_WIDTH-1:0] w_div_sel;
  logic [DIV_WIDTH-1:0] w_cnt_inc;
  logic                 w_step_edge;
  logic                 w_go;
  logic                 w_div_done;
  logic                 w_step_done;
  logic                 w_high_nxt;

  assign w_step_edge = i_step & ~r_step_d;
  assign w_go        = i_enable & ~i_hlt;
  assign w_div_sel   = sel_div(i_speed_sel);
  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_div_done  = (r_cnt == (r_div_q - CNT_ONE));
  assign w_step_done = (r_cnt == STEP_LAST);
  assign w_high_nxt  = (w_state_nxt == ST_RUN_HIGH) || (w_state_nxt == ST_STEP_HIGH);

  // Next-state, counter and divisor-latch decisions for the clock FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div_q;
    case (r_state)
      ST_IDLE: begin
        if (w_go && !i_mode) begin
          w_state_nxt = ST_RUN_LOW;
          w_cnt_nxt   = CNT_ZERO;
          w_div_nxt   = w_div_sel;
        end else if (w_go && i_mode && w_step_edge) begin
          w_state_nxt = ST_STEP_HIGH;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN_LOW: begin
        // Output is already low here, so any stop request can act at once.
        if (!i_enable || i_hlt || i_mode) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_div_done) begin
          w_state_nxt = ST_RUN_HIGH;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_RUN_HIGH: begin
        // Only enable low cuts the high phase; hlt/mode wait for its end.
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_div_done) begin
          if (!i_hlt && !i_mode) begin
            w_state_nxt = ST_RUN_LOW;
            w_cnt_nxt   = CNT_ZERO;
            w_div_nxt   = w_div_sel;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_STEP_HIGH: begin
        // Step edges seen here are dropped rather than queued.
        if (!i_enable || w_step_done) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_div_nxt   = RST_DIV;
      end
    endcase
  end

  // State register plus outputs registered from the next-state decode.
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= CNT_ZERO;
      r_div_q    <= RST_DIV;
      r_step_d   <= 1'b0;
      r_clk_out  <= 1'b0;
      r_clk_rise <= 1'b0;
      r_clk_fall <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_q    <= w_div_nxt;
      r_step_d   <= i_step;
      r_clk_out  <= w_high_nxt;
      r_clk_rise <= w_high_nxt & ~r_clk_out;
      r_clk_fall <= ~w_high_nxt & r_clk_out;
      r_running  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_clk_out  = r_clk_out;
  assign o_clk_rise = r_clk_rise;
  assign o_clk_fall = r_clk_fall;
  assign o_running  = r_running;

endmodule

// File: tb/tb_clk_controller.sv
// Testbench for clk_controller: scenario tasks with a phase/countdown
// reference model. A second instance with DIV_0=0 must behave like DIV_0=1.
module tb_clk_controller;

  localparam int STEP_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, enable = 1'b0, hlt = 1'b0, mode = 1'b0, step = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       clk_out, clk_rise, clk_fall, running;
  logic       z_clk_out, z_clk_rise, z_clk_fall, z_running;
  logic [3:0] w_dut, w_dz;
  assign w_dut = {clk_out, clk_rise, clk_fall, running};
  assign w_dz  = {z_clk_out, z_clk_rise, z_clk_fall, z_running};

  int vectors = 0;
  int miscompares = 0;

  clk_controller #(.DIV_WIDTH(8), .DIV_0(1), .DIV_1(2), .DIV_2(3), .DIV_3(5),
                   .STEP_HIGH_CYCLES(2)) u_dut (
    .i_clk_in(clk), .i_rst(rst), .i_enable(enable), .i_hlt(hlt), .i_mode(mode),
    .i_speed_sel(speed_sel), .i_step(step), .o_clk_out(clk_out),
    .o_clk_rise(clk_rise), .o_clk_fall(clk_fall), .o_running(running));

  clk_controller #(.DIV_WIDTH(8), .DIV_0(0), .DIV_1(2), .DIV_2(3), .DIV_3(5),
                   .STEP_HIGH_CYCLES(2)) u_dut_z (
    .i_clk_in(clk), .i_rst(rst), .i_enable(enable), .i_hlt(hlt), .i_mode(mode),
    .i_speed_sel(speed_sel), .i_step(step), .o_clk_out(z_clk_out),
    .o_clk_rise(z_clk_rise), .o_clk_fall(z_clk_fall), .o_running(z_running));

  // Reference model: a phase plus a count of cycles left in that phase.
  typedef enum {M_OFF, M_LOW, M_HIGH, M_PULSE} mphase_t;
  mphase_t    m_phase = M_OFF;
  int         m_left = 0;
  int         m_div = 1;
  logic       m_step_prev = 1'b0;
  logic [3:0] exp_vec = 4'b0000;

  function automatic int eff_div(input logic [1:0] s);
    int d;
    case (s)
      2'd0: d = 1;
      2'd1: d = 2;
      2'd2: d = 3;
      default: d = 5;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

  task automatic model_step();
    logic was_high, now_high, edge_in;
    edge_in  = step && !m_step_prev;
    was_high = (m_phase == M_HIGH) || (m_phase == M_PULSE);
    if (rst) begin
      m_phase = M_OFF; m_left = 0; m_step_prev = 1'b0; exp_vec = 4'b0000;
    end else begin
      m_step_prev = step;
      case (m_phase)
        M_OFF: begin
          if (enable && !hlt && !mode) begin
            m_div = eff_div(speed_sel); m_left = m_div; m_phase = M_LOW;
          end else if (enable && !hlt && mode && edge_in) begin
            m_phase = M_PULSE; m_left = STEP_W;
          end
        end
        M_LOW: begin
          if (!enable || hlt || mode) m_phase = M_OFF;
          else begin
            m_left--;
            if (m_left == 0) begin m_phase = M_HIGH; m_left = m_div; end
          end
        end
        M_HIGH: begin
          if (!enable) m_phase = M_OFF;
          else begin
            m_left--;
            if (m_left == 0) begin
              if (!hlt && !mode) begin
                m_div = eff_div(speed_sel); m_left = m_div; m_phase = M_LOW;
              end else m_phase = M_OFF;
            end
          end
        end
        default: begin
          if (!enable) m_phase = M_OFF;
          else begin
            m_left--;
            if (m_left == 0) m_phase = M_OFF;
          end
        end
      endcase
      now_high = (m_phase == M_HIGH) || (m_phase == M_PULSE);
      exp_vec = {now_high, now_high && !was_high, !now_high && was_high, m_phase != M_OFF};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    enable = 1'($urandom); mode = 1'($urandom); step = 1'($urandom);
    speed_sel = 2'($urandom);
    for (int t = 0; t < 3; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec} || w_dut !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
    end
  endtask

  task automatic test_free_run();
    int rises[$];
    int falls[$];
    rst = 1'b0; enable = 1'b1; mode = 1'b0; hlt = 1'b0; speed_sel = 2'd3; step = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL free_run t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) rises.push_back(t);
      if (clk_fall) falls.push_back(t);
    end
    vectors++;
    if (rises.size() != 4 || rises[0] != 5) begin
      miscompares++;
      $display("FAIL free_run_first_rise got count %0d first %0d exp count 4 first 5",
               rises.size(), (rises.size() > 0) ? rises[0] : -1);
    end
    vectors++;
    if (rises.size() < 2 || falls.size() < 1 || rises[1] - rises[0] != 10 || falls[0] - rises[0] != 5) begin
      miscompares++;
      $display("FAIL free_run_period got rises %0d falls %0d exp period 10 high 5",
               rises.size(), falls.size());
    end
  endtask

  task automatic test_speed_change();
    int rises[$];
    int falls[$];
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL speed_wait k=%0d got %b/%b exp %b", k, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL speed_wait got no rise exp rise within 20"); end
    for (int t = 1; t <= 14; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL speed_change t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) rises.push_back(t);
      if (clk_fall) falls.push_back(t);
      if (t == 2) speed_sel = 2'd0;
    end
    vectors++;
    if (falls.size() < 2 || rises.size() < 2 || falls[0] != 5 || rises[0] != 6 ||
        falls[1] != 7 || rises[1] != 8) begin
      miscompares++;
      $display("FAIL speed_change_edges got fall0 %0d rise0 %0d exp fall0 5 rise0 6",
               (falls.size() > 0) ? falls[0] : -1, (rises.size() > 0) ? rises[0] : -1);
    end
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(9) == 0) speed_sel = 2'($urandom);
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL speed_random t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
    end
  endtask

  task automatic test_graceful_halt();
    int rises[$];
    int falls[$];
    bit seen_fall = 1'b0;
    bit found = 1'b0;
    speed_sel = 2'd3;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL halt_wait k=%0d got %b/%b exp %b", k, w_dut, w_dz, exp_vec);
      end
      if (clk_fall) seen_fall = 1'b1;
      if (clk_rise && seen_fall) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL halt_wait got no rise exp rise within 40"); end
    for (int t = 1; t <= 20; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL halt t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (t >= 5 && t <= 8) begin
        vectors++;
        if (running !== 1'b0) begin
          miscompares++;
          $display("FAIL halt_idle t=%0d got running %b exp 0", t, running);
        end
      end
      if (clk_rise) rises.push_back(t);
      if (clk_fall) falls.push_back(t);
      if (t == 1) hlt = 1'b1;
      if (t == 8) hlt = 1'b0;
    end
    vectors++;
    if (falls.size() < 1 || rises.size() < 1 || falls[0] != 5 || rises[0] != 14) begin
      miscompares++;
      $display("FAIL halt_timing got fall %0d rise %0d exp fall 5 rise 14",
               (falls.size() > 0) ? falls[0] : -1, (rises.size() > 0) ? rises[0] : -1);
    end
  endtask

  task automatic test_hard_stop();
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL stop_wait k=%0d got %b/%b exp %b", k, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL stop_wait got no rise exp rise within 20"); end
    for (int t = 1; t <= 10; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL hard_stop t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (t == 3) begin
        vectors++;
        if (w_dut !== 4'b0010 || w_dz !== 4'b0010) begin
          miscompares++;
          $display("FAIL hard_stop_fall got %b/%b exp 0010", w_dut, w_dz);
        end
      end
      if (t == 2) enable = 1'b0;
      if (t == 4) enable = 1'b1;
    end
  endtask

  task automatic test_single_step();
    int rises[$];
    int falls[$];
    int n;
    bit ok;
    mode = 1'b1; step = 1'b0; hlt = 1'b0; enable = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL step_settle t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
    end
    for (int t = 0; t < 30; t++) begin
      step = ((t % 10) < 3);
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL step_pulses t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) rises.push_back(t);
      if (clk_fall) falls.push_back(t);
    end
    ok = (rises.size() == 3) && (falls.size() == 3);
    for (int i = 0; i < 3; i++)
      if (ok && (rises[i] != 10 * i || falls[i] != 10 * i + 2)) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL step_count got rises %0d falls %0d exp 3 pulses of width 2",
               rises.size(), falls.size());
    end
    n = 0;
    for (int t = 0; t < 20; t++) begin
      step = (t != 1);
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL step_discard t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) n++;
    end
    vectors++;
    if (n != 1) begin
      miscompares++;
      $display("FAIL step_discard_count got %0d exp 1", n);
    end
    step = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rise_t = -1;
    bit found = 1'b0;
    mode = 1'b0; speed_sel = 2'd3;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL rst_wait k=%0d got %b/%b exp %b", k, w_dut, w_dz, exp_vec);
      end
      if (clk_rise) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL rst_wait got no rise exp rise within 20"); end
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (w_dut !== 4'b0000 || w_dz !== 4'b0000 || exp_vec !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid got %b/%b exp 0000", w_dut, w_dz);
    end
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL rst_restart t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
      if (clk_rise && rise_t < 0) rise_t = t;
    end
    vectors++;
    if (rise_t != 5) begin
      miscompares++;
      $display("FAIL rst_restart_rise got %0d exp 5", rise_t);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 3)  enable = ~enable;
      if ($urandom_range(99) < 5)  hlt = ~hlt;
      if ($urandom_range(99) < 3)  mode = ~mode;
      if ($urandom_range(99) < 5)  speed_sel = 2'($urandom);
      if ($urandom_range(99) < 20) step = ~step;
      tick();
      vectors++;
      if ({w_dut, w_dz} !== {exp_vec, exp_vec}) begin
        miscompares++;
        $display("FAIL random t=%0d got %b/%b exp %b", t, w_dut, w_dz, exp_vec);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_free_run();
    test_speed_change();
    test_graceful_halt();
    test_hard_stop();
    test_single_step();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
